// File: rtl/mdu_sequencer.sv
// RISC-V M-extension sequencer: one shared shift/add datapath, 32 iterations per
// multiply or divide, with single-cycle handling of divide-by-zero and signed overflow.
module mdu_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [4:0]      rd,
  input  logic            pipeline_flush,
  output logic            busy,
  output logic            m_unit_ready,
  output logic            m_unit_wr,
  output logic [XLEN-1:0] m_unit_result,
  output logic [4:0]      m_unit_dest
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic              s1_q, s1_d, s2_q, s2_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic [4:0]        dest_q, dest_d;

  logic              accept, is_div, sgn1, sgn2, div_zero, div_ovf, rem_ge;
  logic [XLEN-1:0]   mag1, mag2, diff, quo_fix, rem_fix, sel;
  logic [XLEN:0]     mul_sum, rem_sh;
  logic [2*XLEN-1:0] step, prod_fix;

  always_comb begin
    accept   = start & (state_q == IDLE) & ~pipeline_flush;
    is_div   = func3[2];
    sgn1     = op1[XLEN-1] & ((func3 == 3'b001) | (func3 == 3'b010) |
                              (func3 == 3'b100) | (func3 == 3'b110));
    sgn2     = op2[XLEN-1] & ((func3 == 3'b001) | (func3 == 3'b100) | (func3 == 3'b110));
    mag1     = sgn1 ? -op1 : op1;
    mag2     = sgn2 ? -op2 : op2;
    div_zero = is_div & (op2 == '0);
    div_ovf  = is_div & ~func3[0] & (op1 == {1'b1, {(XLEN-1){1'b0}}}) & (op2 == '1);

    // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, b_q};
    rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    rem_ge   = rem_sh >= {1'b0, b_q};
    diff     = rem_sh[XLEN-1:0] - b_q;
    if (f3_q[2]) begin
      step = rem_ge ? {diff, acc_q[XLEN-2:0], 1'b1}
                    : {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      step = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
    end

    prod_fix = (s1_q ^ s2_q) ? -step : step;
    quo_fix  = (s1_q ^ s2_q) ? -step[XLEN-1:0] : step[XLEN-1:0];
    rem_fix  = s1_q ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
    case (f3_q)
      3'b000:                 sel = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: sel = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         sel = quo_fix;
      default:                sel = rem_fix;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    b_d     = b_q;
    acc_d   = acc_q;
    res_d   = res_q;
    dest_d  = dest_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          f3_d   = func3;
          dest_d = rd;
          s1_d   = sgn1;
          s2_d   = sgn2;
          b_d    = mag2;
          acc_d  = {{XLEN{1'b0}}, mag1};
          cnt_d  = '0;
          if (div_zero) begin
            res_d   = func3[1] ? op1 : '1;
            state_d = DONE;
          end else if (div_ovf) begin
            res_d   = func3[1] ? '0 : op1;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (pipeline_flush) begin
          state_d = IDLE;
        end else begin
          acc_d = step;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == '1) begin
            res_d   = sel;
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      f3_q    <= '0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      dest_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      dest_q  <= dest_d;
    end
  end

  assign busy          = (state_q == CALC) | accept;
  assign m_unit_ready  = (state_q == DONE) & ~pipeline_flush;
  assign m_unit_wr     = m_unit_ready & (dest_q != '0);
  assign m_unit_result = res_q;
  assign m_unit_dest   = dest_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: driver pushes expected results, a negedge
// monitor pops and compares whenever m_unit_ready is presented.
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, pipeline_flush;
  logic [2:0]  func3;
  logic [31:0] op1, op2;
  logic [4:0]  rd;
  logic        busy, m_unit_ready, m_unit_wr;
  logic [31:0] m_unit_result;
  logic [4:0]  m_unit_dest;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  dest;
    logic        wr;
    int          lat;
    int          t;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  mdu_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .func3(func3), .op1(op1), .op2(op2),
    .rd(rd), .pipeline_flush(pipeline_flush), .busy(busy), .m_unit_ready(m_unit_ready),
    .m_unit_wr(m_unit_wr), .m_unit_result(m_unit_result), .m_unit_dest(m_unit_dest)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model from the ISA definition using wide integer arithmetic
  function automatic logic [31:0] mdl_res(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    int          si, sj;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'b0, b});
    si  = $signed(a);
    sj  = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(si / sj);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(si % sj);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int mdl_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 0)) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issue one op in the cycle after the previous one ended and wait for its result;
  // poke>0 re-asserts start with junk operands mid-operation.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r, input logic [31:0] exp_res, input int lat,
                        input int poke);
    exp_t e;
    int   t0;
    bit   seen;
    @(posedge clk); #1;
    start = 1'b1; func3 = f3; op1 = a; op2 = b; rd = r;
    t0 = cyc;
    e.res = exp_res; e.dest = r; e.wr = (r != 0); e.lat = lat; e.t = t0;
    q.push_back(e);
    @(negedge clk);
    chk("busy_accept", busy, 1);
    @(posedge clk); #1;
    start = 1'b0; func3 = 3'($urandom); op1 = $urandom; op2 = $urandom; rd = 5'($urandom);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      chk("busy_window", busy, 32'((cyc - t0) < lat));
      if (m_unit_ready) seen = 1;
      start = (poke > 0 && (cyc - t0) == poke && lat > poke + 2);
    end
    start = 1'b0;
    if (!seen) begin
      checks++; errors++;
      $display("FAIL timeout actual=no_ready required=ready f3=%0d a=%h b=%h", f3, a, b);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: decoupled from stimulus, compares whatever the DUT presents
  always @(negedge clk) begin
    if (!rst) begin
      if (m_unit_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ready actual=%h required=none", m_unit_result);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("result", m_unit_result, e.res);
          chk("wr", m_unit_wr, e.wr);
          chk("dest", m_unit_dest, e.dest);
          chk("latency", cyc - e.t, e.lat);
        end
      end else begin
        chk("wr_gated", m_unit_wr, 0);
      end
    end
  end

  typedef struct { logic [2:0] f3; logic [31:0] a, b; logic [4:0] r; logic [31:0] res; int lat; } dir_t;
  dir_t dir[12] = '{
    '{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33},
    '{3'd1, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, 33},
    '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 33},
    '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 33},
    '{3'd4, 32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFD, 33},
    '{3'd6, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFF, 33},
    '{3'd5, 32'd100,       32'd7,         5'd11, 32'd14,        33},
    '{3'd7, 32'd100,       32'd7,         5'd0,  32'd2,         33},
    '{3'd5, 32'd5,         32'd0,         5'd12, 32'hFFFF_FFFF, 1},
    '{3'd6, 32'd5,         32'd0,         5'd13, 32'd5,         1},
    '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1},
    '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h0,         1}
  };

  initial begin
    bit seen;
    rst = 1'b1; start = 1'b0; pipeline_flush = 1'b0;
    func3 = '0; op1 = '0; op2 = '0; rd = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ready", m_unit_ready, 0);
    chk("rst_wr", m_unit_wr, 0);
    chk("rst_result", m_unit_result, 0);
    chk("rst_dest", m_unit_dest, 0);
    @(posedge clk); #1 rst = 1'b0;

    foreach (dir[i])
      run_op(dir[i].f3, dir[i].a, dir[i].b, dir[i].r, dir[i].res, dir[i].lat, (i == 0) ? 5 : 0);

    // Flush when the iteration counter reads 10
    @(posedge clk); #1;
    start = 1'b1; func3 = 3'd0; op1 = 32'd9; op2 = 32'd9; rd = 5'd3;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 pipeline_flush = 1'b1;
    @(negedge clk);
    chk("flush_ready", m_unit_ready, 0);
    chk("flush_wr", m_unit_wr, 0);
    @(posedge clk); #1 pipeline_flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", busy, 0);
    run_op(3'd0, 32'd3, 32'd4, 5'd4, 32'd12, 33, 0);

    // Reset mid-calculation, with start asserted alongside it
    @(posedge clk); #1;
    start = 1'b1; func3 = 3'd1; op1 = 32'h1234_5678; op2 = 32'h9ABC_DEF0; rd = 5'd20;
    @(posedge clk); #1 start = 1'b0;
    repeat (14) @(posedge clk);
    #1 rst = 1'b1; start = 1'b1;
    @(posedge clk); #1 rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", m_unit_ready, 0);
    chk("midrst_wr", m_unit_wr, 0);
    chk("midrst_result", m_unit_result, 0);
    chk("midrst_dest", m_unit_dest, 0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (m_unit_ready) seen = 1;
    end
    chk("midrst_noready", 32'(seen), 0);

    for (int n = 0; n < 60; n++) begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      logic [4:0]  r;
      f3 = 3'($urandom_range(0, 7));
      a = pick(); b = pick();
      r = 5'($urandom_range(0, 31));
      run_op(f3, a, b, r, mdl_res(f3, a, b), mdl_lat(f3, a, b), ($urandom_range(0, 3) == 0) ? 6 : 0);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
